// File: rtl/level_flow_sm_if.sv
// level_flow_sm_if: keypad/collision/tick inputs and screen/counter outputs of the game-flow controller.
// master drives start_key, pause_key, hit_pulse, goal_hit, one_sec_pulse and observes the outputs;
// slave (the controller) consumes those inputs and drives the screen flags, level_load, level, lives, time_left.
interface level_flow_sm_if #(
  parameter int NUM_LEVELS     = 3,
  parameter int START_LIVES    = 3,
  parameter int LEVEL_TIME_SEC = 60
);
  localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int LIFE_W = $clog2(START_LIVES + 1);
  localparam int TIME_W = $clog2(LEVEL_TIME_SEC + 1);

  // inputs to the controller
  logic start_key;
  logic pause_key;
  logic hit_pulse;
  logic goal_hit;
  logic one_sec_pulse;

  // one-hot screen flags
  logic start_st;
  logic play_st;
  logic pause_st;
  logic level_st;
  logic winner_st;
  logic loser_st;
  logic game_over;

  // object reload and counters
  logic              level_load;
  logic [LVL_W-1:0]  level;
  logic [LIFE_W-1:0] lives;
  logic [TIME_W-1:0] time_left;

  modport master (
    output start_key, pause_key, hit_pulse, goal_hit, one_sec_pulse,
    input  start_st, play_st, pause_st, level_st, winner_st, loser_st, game_over,
    input  level_load, level, lives, time_left
  );

  modport slave (
    input  start_key, pause_key, hit_pulse, goal_hit, one_sec_pulse,
    output start_st, play_st, pause_st, level_st, winner_st, loser_st, game_over,
    output level_load, level, lives, time_left
  );
endinterface

// File: rtl/level_flow_sm.sv
// level_flow_sm: multi-level game-flow controller (start/play/pause/intermission/win/lose/over screens).
// Latency: pulses act on the edge that samples them; keys are edge-registered first and act one edge later.
// No backpressure: pulses/key edges arriving in a state that does not use them are dropped, never queued.
// Ports: clk, reset (async active-high), bus (level_flow_sm_if.slave) carrying keys, collision pulses,
// 1 Hz tick, one-hot screen flags, level_load pulse and the level/lives/time_left counters.
// The interface instance must be built with the same NUM_LEVELS/START_LIVES/LEVEL_TIME_SEC values.
module level_flow_sm #(
  parameter int NUM_LEVELS     = 3,
  parameter int START_LIVES    = 3,
  parameter int LEVEL_TIME_SEC = 60,
  parameter int END_SEC        = 2
) (
  input  logic             clk,
  input  logic             reset,
  level_flow_sm_if.slave   bus
);

  localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int LIFE_W = $clog2(START_LIVES + 1);
  localparam int TIME_W = $clog2(LEVEL_TIME_SEC + 1);
  localparam int DW_W   = $clog2(END_SEC + 1);

  localparam logic [LVL_W-1:0]  LAST_LVL  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(START_LIVES);
  localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(LEVEL_TIME_SEC);
  localparam logic [DW_W-1:0]   DW_LAST   = DW_W'(END_SEC - 1);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_LEVEL = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t state_q;
  state_t state_nxt;

  // key edge detection: the edge itself is registered, so a key acts one edge after it is seen
  logic start_d;
  logic pause_d;
  logic start_ev;
  logic pause_ev;

  logic [LVL_W-1:0]  level_q;
  logic [LIFE_W-1:0] lives_q;
  logic [TIME_W-1:0] time_q;
  logic [DW_W-1:0]   dwell_q;
  logic              level_load_q;

  logic in_dwell;
  logic dwell_done;
  logic play_lose;
  logic last_level;

  logic f_start, f_play, f_pause, f_level, f_win, f_lose, f_over;

  assign last_level = (level_q == LAST_LVL);
  assign in_dwell   = (state_q == S_LEVEL) || (state_q == S_WIN) || (state_q == S_LOSE);
  // exit on the tick that would bring the dwell count up to END_SEC
  assign dwell_done = in_dwell && bus.one_sec_pulse && (dwell_q == DW_LAST);
  // hit and tick both apply in the same cycle; either exhausting its counter loses the game
  assign play_lose  = (bus.hit_pulse     && (lives_q <= LIFE_W'(1))) ||
                      (bus.one_sec_pulse && (time_q  <= TIME_W'(1)));

  // key edge registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_d  <= 1'b0;
      pause_d  <= 1'b0;
      start_ev <= 1'b0;
      pause_ev <= 1'b0;
    end else begin
      start_d  <= bus.start_key;
      pause_d  <= bus.pause_key;
      start_ev <= bus.start_key & ~start_d;
      pause_ev <= bus.pause_key & ~pause_d;
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_START: begin
        if (start_ev) state_nxt = S_PLAY;
      end
      S_PLAY: begin
        // goal outranks everything; a pause only takes effect when nothing else fires
        if (bus.goal_hit)   state_nxt = last_level ? S_WIN : S_LEVEL;
        else if (play_lose) state_nxt = S_LOSE;
        else if (pause_ev)  state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_ev) state_nxt = S_PLAY;
      end
      S_LEVEL: begin
        if (dwell_done) state_nxt = S_PLAY;
      end
      S_WIN, S_LOSE: begin
        if (dwell_done) state_nxt = S_OVER;
      end
      S_OVER: begin
        if (start_ev) state_nxt = S_START;
      end
      default: state_nxt = S_START;
    endcase
  end

  // Moore flag decode
  always_comb begin
    f_start = 1'b0;
    f_play  = 1'b0;
    f_pause = 1'b0;
    f_level = 1'b0;
    f_win   = 1'b0;
    f_lose  = 1'b0;
    f_over  = 1'b0;
    case (state_q)
      S_START: f_start = 1'b1;
      S_PLAY:  f_play  = 1'b1;
      S_PAUSE: f_pause = 1'b1;
      S_LEVEL: f_level = 1'b1;
      S_WIN:   f_win   = 1'b1;
      S_LOSE:  f_lose  = 1'b1;
      S_OVER:  f_over  = 1'b1;
      default: f_start = 1'b1;
    endcase
  end

  // life, time and level counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lives_q <= LIFE_INIT;
      time_q  <= TIME_INIT;
      level_q <= '0;
    end else begin
      case (state_q)
        S_START: begin
          lives_q <= LIFE_INIT;
          time_q  <= TIME_INIT;
          level_q <= '0;
        end
        S_PLAY: begin
          // a goal freezes the counters even if a hit or tick lands in the same cycle
          if (!bus.goal_hit) begin
            if (bus.hit_pulse && (lives_q != '0))
              lives_q <= lives_q - LIFE_W'(1);
            if (bus.one_sec_pulse && (time_q != '0))
              time_q <= time_q - TIME_W'(1);
          end
        end
        S_LEVEL: begin
          if (dwell_done) begin
            level_q <= level_q + LVL_W'(1);
            time_q  <= TIME_INIT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // dwell counter: zero on every state change, counts ticks only in the end/intermission screens
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q <= '0;
    end else if (state_nxt != state_q) begin
      dwell_q <= '0;
    end else if (in_dwell && bus.one_sec_pulse) begin
      dwell_q <= dwell_q + DW_W'(1);
    end
  end

  // level_load lands on the first PLAY cycle after a fresh start or an intermission, never after pause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_load_q <= 1'b0;
    end else begin
      level_load_q <= (state_nxt == S_PLAY) &&
                      ((state_q == S_START) || (state_q == S_LEVEL));
    end
  end

  assign bus.start_st   = f_start;
  assign bus.play_st    = f_play;
  assign bus.pause_st   = f_pause;
  assign bus.level_st   = f_level;
  assign bus.winner_st  = f_win;
  assign bus.loser_st   = f_lose;
  assign bus.game_over  = f_over;
  assign bus.level_load = level_load_q;
  assign bus.level      = level_q;
  assign bus.lives      = lives_q;
  assign bus.time_left  = time_q;

endmodule

// File: tb/tb_level_flow_sm.sv
// tb_level_flow_sm: directed game scenarios against a screen/lives/seconds model of the game flow.
// Inputs change 2 time units after each rising edge; outputs are compared on every falling edge.
module tb_level_flow_sm;

  localparam int NL = 3;
  localparam int SL = 3;
  localparam int LT = 60;
  localparam int ES = 2;

  // screen indices, in the bit order of act_flags below
  localparam int SC_START = 0;
  localparam int SC_PLAY  = 1;
  localparam int SC_PAUSE = 2;
  localparam int SC_LEVEL = 3;
  localparam int SC_WIN   = 4;
  localparam int SC_LOSE  = 5;
  localparam int SC_OVER  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  level_flow_sm_if #(.NUM_LEVELS(NL), .START_LIVES(SL), .LEVEL_TIME_SEC(LT)) bus ();

  level_flow_sm #(
    .NUM_LEVELS(NL), .START_LIVES(SL), .LEVEL_TIME_SEC(LT), .END_SEC(ES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  logic [6:0] act_flags;
  assign act_flags = {bus.game_over, bus.loser_st, bus.winner_st, bus.level_st,
                      bus.pause_st, bus.play_st, bus.start_st};

  // ---------------- behavioural model ----------------
  int m_scr, m_lives, m_time, m_level, m_secs;
  bit m_load, m_s_prev, m_p_prev, m_s_ev, m_p_ev;

  always @(posedge clk or posedge reset) begin : model
    bit s_go, p_go, dead;
    if (reset) begin
      m_scr = SC_START; m_lives = SL; m_time = LT; m_level = 0; m_secs = 0;
      m_load = 0; m_s_prev = 0; m_p_prev = 0; m_s_ev = 0; m_p_ev = 0;
    end else begin
      s_go = m_s_ev;
      p_go = m_p_ev;
      m_s_ev = bus.start_key && !m_s_prev;
      m_p_ev = bus.pause_key && !m_p_prev;
      m_s_prev = bus.start_key;
      m_p_prev = bus.pause_key;
      m_load = 0;
      case (m_scr)
        SC_START: begin
          m_lives = SL; m_level = 0; m_time = LT;
          if (s_go) begin m_scr = SC_PLAY; m_load = 1; end
        end
        SC_PLAY: begin
          if (bus.goal_hit) begin
            m_scr = (m_level == NL - 1) ? SC_WIN : SC_LEVEL;
            m_secs = 0;
          end else begin
            dead = 0;
            if (bus.hit_pulse) begin
              if (m_lives > 0) m_lives = m_lives - 1;
              if (m_lives == 0) dead = 1;
            end
            if (bus.one_sec_pulse) begin
              if (m_time > 0) m_time = m_time - 1;
              if (m_time == 0) dead = 1;
            end
            if (dead) begin m_scr = SC_LOSE; m_secs = 0; end
            else if (p_go) m_scr = SC_PAUSE;
          end
        end
        SC_PAUSE: if (p_go) m_scr = SC_PLAY;
        SC_LEVEL, SC_WIN, SC_LOSE: begin
          if (bus.one_sec_pulse) begin
            m_secs = m_secs + 1;
            if (m_secs >= ES) begin
              if (m_scr == SC_LEVEL) begin
                m_level = m_level + 1; m_time = LT; m_load = 1; m_scr = SC_PLAY;
              end else begin
                m_scr = SC_OVER;
              end
            end
          end
        end
        SC_OVER: if (s_go) m_scr = SC_START;
        default: m_scr = SC_START;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [6:0] exp_flags;
    if (!reset) begin
      exp_flags = 7'(1) << m_scr;
      checks++;
      if (act_flags !== exp_flags || bus.level_load !== m_load ||
          int'(bus.level) != m_level || int'(bus.lives) != m_lives ||
          int'(bus.time_left) != m_time) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual flags=%b load=%b level=%0d lives=%0d time=%0d required flags=%b load=%b level=%0d lives=%0d time=%0d",
                 $time, act_flags, bus.level_load, bus.level, bus.lives, bus.time_left,
                 exp_flags, m_load, m_level, m_lives, m_time);
      end
      if (bus.level_load === 1'b1) load_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic h, input logic g, input logic t);
    bus.hit_pulse = h; bus.goal_hit = g; bus.one_sec_pulse = t;
    cycles(1);
    bus.hit_pulse = 1'b0; bus.goal_hit = 1'b0; bus.one_sec_pulse = 1'b0;
  endtask

  task automatic press_start(input int hold);
    bus.start_key = 1'b1;
    cycles(hold);
    bus.start_key = 1'b0;
    cycles(1);
  endtask

  task automatic press_pause(input int hold);
    bus.pause_key = 1'b1;
    cycles(hold);
    bus.pause_key = 1'b0;
    cycles(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse(1'b0, 1'b0, 1'b1);
  endtask

  // from OVER: back to START, let START reload, then into PLAY
  task automatic new_game();
    press_start(1);
    cycles(1);
    press_start(1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n0;
    reset = 1'b1;
    bus.start_key = 1'b0; bus.pause_key = 1'b0;
    bus.hit_pulse = 1'b0; bus.goal_hit = 1'b0; bus.one_sec_pulse = 1'b0;
    #12;
    chk("reset_start_st", bus.start_st, 1);
    chk("reset_flags", int'(act_flags), 1);
    chk("reset_level_load", bus.level_load, 0);
    chk("reset_lives", bus.lives, 3);
    chk("reset_time", bus.time_left, 60);
    reset = 1'b0;

    // held start key: one transition, one load pulse
    press_start(10);
    chk("start_hold_loads", load_cnt, 1);
    chk("start_play_st", bus.play_st, 1);
    chk("start_lives", bus.lives, 3);
    chk("start_time", bus.time_left, 60);
    chk("start_level", bus.level, 0);

    // three hits lose the game
    pulse(1, 0, 0); chk("hit1_lives", bus.lives, 2);
    pulse(1, 0, 0); chk("hit2_lives", bus.lives, 1);
    pulse(1, 0, 0); chk("hit3_lives", bus.lives, 0);
    chk("hit3_loser", bus.loser_st, 1);
    ticks(1);       chk("lose_dwell1", bus.loser_st, 1);
    ticks(1);       chk("lose_over", bus.game_over, 1);
    press_start(1); chk("over_to_start", bus.start_st, 1);
    cycles(1);      chk("start_reload_lives", bus.lives, 3);

    // level progression to a win
    press_start(1);
    pulse(0, 1, 0); chk("goal0_level_st", bus.level_st, 1);
    ticks(2);
    chk("lvl1_play", bus.play_st, 1);
    chk("lvl1_level", bus.level, 1);
    chk("lvl1_time", bus.time_left, 60);
    chk("lvl1_load", bus.level_load, 1);
    ticks(1);       chk("lvl1_tick_time", bus.time_left, 59);
    pulse(0, 1, 0); ticks(2);
    chk("lvl2_level", bus.level, 2);
    pulse(0, 1, 0); chk("goal2_winner", bus.winner_st, 1);
    ticks(2);       chk("win_over", bus.game_over, 1);
    chk("win_over_level", bus.level, 2);

    // goal beats a same-cycle hit on the last life
    new_game();
    pulse(1, 0, 0); pulse(1, 0, 0);
    pulse(1, 1, 0);
    chk("goal_hit_level_st", bus.level_st, 1);
    chk("goal_hit_lives", bus.lives, 1);
    ticks(2);
    pulse(1, 0, 0); chk("last_life_lose", bus.loser_st, 1);
    ticks(2);

    // hit and tick together with one second left
    new_game();
    ticks(59);      chk("time_one", bus.time_left, 1);
    pulse(1, 0, 1);
    chk("hit_tick_loser", bus.loser_st, 1);
    chk("hit_tick_lives", bus.lives, 2);
    chk("hit_tick_time", bus.time_left, 0);
    ticks(2);

    // pause freezes everything and resumes without a reload
    new_game();
    press_pause(3); chk("pause_st", bus.pause_st, 1);
    ticks(5);
    pulse(1, 0, 0); pulse(1, 0, 0);
    chk("pause_time", bus.time_left, 60);
    chk("pause_lives", bus.lives, 3);
    press_start(1); chk("pause_ignores_start", bus.pause_st, 1);
    n0 = load_cnt;
    press_pause(1); chk("resume_play", bus.play_st, 1);
    cycles(2);      chk("resume_no_load", load_cnt, n0);

    // asynchronous reset in WIN with one dwell second counted
    pulse(0, 1, 0); ticks(2);
    pulse(0, 1, 0); ticks(2);
    pulse(0, 1, 0); ticks(1);
    chk("pre_reset_winner", bus.winner_st, 1);
    #1 reset = 1'b1;
    #1;
    chk("areset_flags", int'(act_flags), 1);
    chk("areset_load", bus.level_load, 0);
    chk("areset_level", bus.level, 0);
    chk("areset_lives", bus.lives, 3);
    chk("areset_time", bus.time_left, 60);
    #2 reset = 1'b0;
    cycles(3);
    chk("post_reset_start", bus.start_st, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
